// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_ctrl
// Brief    : UART 8N1/8N2 transmit sequencer on a 4x-oversampled baud tick.
//            Owns the baud generator rate select and changes it only between
//            frames. Define UART_TX_PARITY_EN to insert an even parity bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl #(
    parameter int         OVERSAMPLE = 4,
    parameter int         STOP_BITS  = 1,
    parameter logic [1:0] RESET_BAUD = 2'b11
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       baudtick,
    output logic [1:0] baudtick_ctrl,
    input  logic       cfg_wr,
    input  logic [1:0] cfg_baud_sel,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd,
    output logic       busy
);

    localparam int                 c_CNT_W     = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(OVERSAMPLE - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic               c_STOP_LAST = 1'(STOP_BITS - 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_ALIGN  = 3'd1;
    localparam logic [2:0] c_ST_START  = 3'd2;
    localparam logic [2:0] c_ST_DATA   = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] c_ST_PARITY = 3'd5;
`endif

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic               r_stop_idx;
    logic [7:0]         r_data;
    logic               r_txd;
    logic               r_tx_ready;
    logic               r_busy;
    logic [1:0]         r_baud;
    logic [1:0]         r_pend_sel;
    logic               r_pend_vld;

    logic               w_accept;
    logic               w_in_bit;
    logic               w_bit_end;
    logic [2:0]         w_idx_nxt;
`ifdef UART_TX_PARITY_EN
    logic               w_parity;
    assign w_parity = ^r_data;
`endif

    // tx_ready is high exactly in IDLE, so it doubles as the IDLE qualifier
    assign w_accept  = tx_valid & r_tx_ready;
    assign w_in_bit  = (r_state != c_ST_IDLE) && (r_state != c_ST_ALIGN);
    assign w_bit_end = baudtick && (r_cnt == c_CNT_LAST);
    assign w_idx_nxt = r_bit_idx + 3'd1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= 3'd0;
            r_stop_idx <= 1'b0;
            r_data     <= 8'h00;
            r_txd      <= 1'b1;
            r_tx_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_baud     <= RESET_BAUD;
            r_pend_sel <= 2'b00;
            r_pend_vld <= 1'b0;
        end else begin
            // Rate writes outside a quiet IDLE cycle are parked; last write wins
            if (cfg_wr) begin
                if ((r_state == c_ST_IDLE) && !w_accept) begin
                    r_baud <= cfg_baud_sel;
                end else begin
                    r_pend_sel <= cfg_baud_sel;
                    r_pend_vld <= 1'b1;
                end
            end

            if (w_in_bit && baudtick) begin
                r_cnt <= w_bit_end ? '0 : r_cnt + c_CNT_ONE;
            end

            case (r_state)
                c_ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_accept) begin
                        r_data     <= tx_data;
                        r_state    <= c_ST_ALIGN;
                        r_tx_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end

                // Waiting for a tick here makes the start bit a full bit period
                c_ST_ALIGN: begin
                    r_cnt <= '0;
                    if (baudtick) begin
                        r_state <= c_ST_START;
                        r_txd   <= 1'b0;
                    end
                end

                c_ST_START: begin
                    if (w_bit_end) begin
                        r_state   <= c_ST_DATA;
                        r_bit_idx <= 3'd0;
                        r_txd     <= r_data[0];
                    end
                end

                c_ST_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= c_ST_PARITY;
                            r_txd   <= w_parity;
`else
                            r_state    <= c_ST_STOP;
                            r_stop_idx <= 1'b0;
                            r_txd      <= 1'b1;
`endif
                        end else begin
                            r_bit_idx <= w_idx_nxt;
                            r_txd     <= r_data[w_idx_nxt];
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                c_ST_PARITY: begin
                    if (w_bit_end) begin
                        r_state    <= c_ST_STOP;
                        r_stop_idx <= 1'b0;
                        r_txd      <= 1'b1;
                    end
                end
`endif

                c_ST_STOP: begin
                    if (w_bit_end) begin
                        if (r_stop_idx == c_STOP_LAST) begin
                            r_state    <= c_ST_IDLE;
                            r_tx_ready <= 1'b1;
                            r_busy     <= 1'b0;
                            r_pend_vld <= 1'b0;
                            // A write landing on the exit edge is newer than the parked one
                            if (cfg_wr) begin
                                r_baud <= cfg_baud_sel;
                            end else if (r_pend_vld) begin
                                r_baud <= r_pend_sel;
                            end
                        end else begin
                            r_stop_idx <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state    <= c_ST_IDLE;
                    r_cnt      <= '0;
                    r_txd      <= 1'b1;
                    r_tx_ready <= 1'b1;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign baudtick_ctrl = r_baud;
    assign tx_ready      = r_tx_ready;
    assign txd           = r_txd;
    assign busy          = r_busy;

endmodule
`default_nettype wire
